pc_sequencer: RTL and testbench

- Owns the MIPS program counter and sequences instruction fetch via a request/acknowledge handshake to instruction memory.
- Computes PC+4 internally as a 32-bit add, and selects between sequential, branch, jump and exception next-PC sources.
- Supports stall, and discards in-flight fetches that have been overtaken by a redirect.
- Sits between the control unit and the instruction memory port, replacing the free-running PC register.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the MIPS PC and sequences instruction fetch over a req/ack port.
// Optional macro PC_ALIGN_CHECK_EN: misaligned jump/branch targets divert to EXC_VECTOR and pulse addr_error.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        fetch_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        addr_error
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redir_q;
    logic            kill_q;
    logic            req_q;

    logic            redir_any;
    logic [XLEN-1:0] redir_tgt;
    logic            align_err;

    // Winning redirect target under fixed priority exception > jump > branch.
    always_comb begin
        redir_any = exception | jump | branch_taken;
        redir_tgt = branch_target;
        align_err = 1'b0;
        if (exception) begin
            redir_tgt = EXC_VECTOR;
        end else if (jump) begin
            redir_tgt = jump_target;
        end
`ifdef PC_ALIGN_CHECK_EN
        if (!exception && redir_any && (redir_tgt[1:0] != 2'b00)) begin
            align_err = 1'b1;
            redir_tgt = EXC_VECTOR;
        end
`endif
    end

    // Fetch sequencing: a redirect during an outstanding request is parked and the fetch killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc_q    <= RESET_VECTOR;
            redir_q <= '0;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (redir_any) begin
                        pc_q <= redir_tgt;
                    end
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (redir_any) begin
                            pc_q <= redir_tgt;
                        end else if (kill_q) begin
                            pc_q <= redir_q;
                        end else begin
                            pc_q <= pc_plus4;
                        end
                        kill_q  <= 1'b0;
                        redir_q <= '0;
                        if (stall) begin
                            state <= HOLD;
                            req_q <= 1'b0;
                        end else begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end
                    end else if (redir_any) begin
                        redir_q <= redir_tgt;
                        kill_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir_any) begin
                        pc_q <= redir_tgt;
                    end
                    if (!stall) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_STEP;
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign fetch_valid = req_q & imem_ack & ~kill_q;
    assign addr_error  = align_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_error;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exception    (exception),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .addr_error   (addr_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: phase 0 = boot, 1 = fetching, 2 = stalled.
    // m_follow is where the PC goes after the outstanding fetch completes.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_follow;
    logic        m_killed;
    logic        t_redir;
    logic        t_err;
    logic [31:0] t_tgt;
    logic [31:0] t_npc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_pc     <= RST_VEC;
            m_follow <= RST_VEC + 32'd4;
            m_killed <= 1'b0;
        end else begin
            t_redir = exception | jump | branch_taken;
            t_tgt   = exception ? EXC_VEC : (jump ? jump_target : branch_target);
            t_err   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (t_redir && !exception && (t_tgt % 4 != 0)) begin
                t_err = 1'b1;
                t_tgt = EXC_VEC;
            end
`endif
            chk("req", 32'(imem_req), 32'(m_phase == 1));
            if (m_phase == 1) chk("addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("fetch_valid", 32'(fetch_valid), 32'(m_phase == 1 && imem_ack && !m_killed));
            chk("addr_error", 32'(addr_error), 32'(t_err));
            case (m_phase)
                0: begin
                    t_npc = t_redir ? t_tgt : m_pc;
                    m_pc     <= t_npc;
                    m_follow <= t_npc + 32'd4;
                    m_killed <= 1'b0;
                    m_phase  <= 1;
                end
                1: begin
                    if (imem_ack) begin
                        t_npc = t_redir ? t_tgt : m_follow;
                        m_pc     <= t_npc;
                        m_follow <= t_npc + 32'd4;
                        m_killed <= 1'b0;
                        m_phase  <= stall ? 2 : 1;
                    end else if (t_redir) begin
                        m_follow <= t_tgt;
                        m_killed <= 1'b1;
                    end
                end
                default: begin
                    t_npc = t_redir ? t_tgt : m_pc;
                    m_pc     <= t_npc;
                    m_follow <= t_npc + 32'd4;
                    if (!stall) m_phase <= 1;
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic ack, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic ex);
        stall         = st;
        imem_ack      = ack;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        exception     = ex;
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(3) != 0) v[1:0] = 2'b00;
        if ($urandom_range(15) == 0) v = 32'hFFFF_FFFC;
        return v;
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            drive(($urandom_range(3) == 0), ($urandom_range(1) == 1),
                  ($urandom_range(7) == 0), rand_tgt(),
                  ($urandom_range(7) == 0), rand_tgt(),
                  ($urandom_range(15) == 0));
        end
    endtask

    logic [31:0] exp_err;
    logic [31:0] exp_jaddr;

    initial begin
`ifdef PC_ALIGN_CHECK_EN
        exp_err   = 32'd1;
        exp_jaddr = 32'h0000_0080;
`else
        exp_err   = 32'd0;
        exp_jaddr = 32'h0000_0102;
`endif
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_aerr", 32'(addr_error), 32'd0);
        rst_n = 1'b1;
        #2;
        chk("boot_req", 32'(imem_req), 32'd0);
        // Back-to-back fetches with ack tied high.
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            #2;
            chk("seq_addr", imem_addr, 32'(i * 4));
            chk("seq_fv", 32'(fetch_valid), 32'd1);
        end
        // Wait states at 0x10.
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive(1'b0, (i == 3), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            #2;
            chk("ws_req", 32'(imem_req), 32'd1);
            chk("ws_addr", imem_addr, 32'h10);
            chk("ws_fv", 32'(fetch_valid), 32'(i == 3));
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            #2;
            chk("post_ws_addr", imem_addr, 32'h14 + 32'(i * 4));
        end
        // Branch overtakes the pending fetch at 0x20.
        cyc();
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        #2;
        chk("kill_addr0", imem_addr, 32'h20);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("kill_addr1", imem_addr, 32'h20);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("kill_fv", 32'(fetch_valid), 32'd0);
        // All redirects at once: exception wins.
        cyc();
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1);
        #2;
        chk("br_addr", imem_addr, 32'h100);
        chk("br_fv", 32'(fetch_valid), 32'd1);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30, 1'b0);
        #2;
        chk("exc_addr", imem_addr, 32'h80);
        // Stall after ack at 0x30.
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("st_addr", imem_addr, 32'h30);
        chk("st_fv", 32'(fetch_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive((i < 2), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            #2;
            chk("st_req", 32'(imem_req), 32'd0);
            chk("st_pc", pc, 32'h34);
            chk("st_fv_hold", 32'(fetch_valid), 32'd0);
        end
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
        #2;
        chk("resume_addr", imem_addr, 32'h34);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("align_err", 32'(addr_error), exp_err);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        #2;
        chk("align_addr", imem_addr, exp_jaddr);
        chk("align_err_gone", 32'(addr_error), 32'd0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("wrap_next", imem_addr, 32'h0);

        rand_cycles(3000);

        // Reset asserted while a request is outstanding.
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        #2;
        chk("mid_req_pre", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("mid_req_drop", 32'(imem_req), 32'd0);
        chk("mid_fv", 32'(fetch_valid), 32'd0);
        chk("mid_pc", pc, RST_VEC);
        repeat (2) cyc();
        rst_n = 1'b1;
        rand_cycles(200);

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
